// File: rtl/duty_ramp_pkg.sv
// duty_ramp_pkg: shared address map, RAMP_CTRL field layout and ramp FSM encoding.
// Revision: 1.0
`default_nettype none

package duty_ramp_pkg;

  localparam logic [6:0] ADDR_DUTY        = 7'h04;
  localparam logic [6:0] ADDR_RAMP_CTRL   = 7'h05;
  localparam logic [6:0] ADDR_RAMP_PERIOD = 7'h06;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_LOOP_BIT = 1;
  localparam int CTRL_STEP_LSB = 4;
  localparam int CTRL_STEP_MSB = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_e;

  // A programmed step of zero still moves the ramp by one.
  function automatic logic [7:0] eff_step(input logic [3:0] step);
    return (step == 4'd0) ? 8'd1 : {4'd0, step};
  endfunction

endpackage

`default_nettype wire

// File: rtl/duty_ramp_arbiter_tick_gen.sv
// ramp_tick_gen: prescaler plus period counter; tick is high for one cycle when both are terminal.
// Revision: 1.0
`default_nettype none

module ramp_tick_gen #(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] period,
  output logic       tick
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [7:0]            per_q, per_d;
  logic                  pre_term;
  logic                  per_term;

  // Compare with >= so a period shortened mid-count still terminates.
  always_comb begin
    pre_term = (pre_q >= PRE_LAST);
    per_term = (per_q >= period);
    tick     = en && !clear && pre_term && per_term;
    pre_d    = pre_q;
    per_d    = per_q;
    if (clear) begin
      pre_d = '0;
      per_d = '0;
    end else if (en) begin
      if (pre_term) begin
        pre_d = '0;
        per_d = per_term ? 8'd0 : per_q + 8'd1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      per_q <= '0;
    end else begin
      pre_q <= pre_d;
      per_q <= per_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/duty_ramp_arbiter.sv
// duty_ramp_arbiter: single bank write port shared by host writes (priority) and a duty ramp engine.
// Optional ramp_done pulse output when RAMP_DONE_IRQ_EN is defined.  Revision: 1.0
`default_nettype none

module duty_ramp_arbiter
  import duty_ramp_pkg::*;
#(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_wr_valid,
  input  logic [6:0] host_wr_addr,
  input  logic [7:0] host_wr_data,
  output logic       bank_wr_en,
  output logic [6:0] bank_wr_addr,
  output logic [7:0] bank_wr_data,
  output logic       ramp_busy,
  output logic       ramp_stall
`ifdef RAMP_DONE_IRQ_EN
  ,
  output logic       ramp_done
`endif
);

  ramp_state_e state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic        loop_q, loop_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  period_q, period_d;
  logic        pend_q, pend_d;
  logic        bank_en_q, bank_en_d;
  logic [6:0]  bank_addr_q, bank_addr_d;
  logic [7:0]  bank_data_q, bank_data_d;
  logic        stall_q, stall_d;

  logic       host_fwd, host_duty, host_ctrl, host_period;
  logic       ctrl_dis, start;
  logic       tick, ramp_tick, ramp_req;
  logic [7:0] step;
  logic [8:0] sum, diff;

  always_comb begin
    host_fwd    = host_wr_valid && (host_wr_addr <= ADDR_DUTY);
    host_duty   = host_wr_valid && (host_wr_addr == ADDR_DUTY);
    host_ctrl   = host_wr_valid && (host_wr_addr == ADDR_RAMP_CTRL);
    host_period = host_wr_valid && (host_wr_addr == ADDR_RAMP_PERIOD);
    ctrl_dis    = host_ctrl && !host_wr_data[CTRL_EN_BIT];
    start       = host_ctrl && host_wr_data[CTRL_EN_BIT] && (state_q == IDLE);
    step        = eff_step(step_q);
    sum         = {1'b0, acc_q} + {1'b0, step};
    diff        = {1'b0, acc_q} - {1'b0, step};
    // A duty load or a disable in the tick cycle supersedes the tick.
    ramp_tick   = tick && (state_q != IDLE) && !ctrl_dis && !host_duty;
  end

  ramp_tick_gen #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .en     (state_q != IDLE),
    .period (period_q),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (ctrl_dis)   state_d = IDLE;
    else if (start) state_d = UP;
    if (host_duty) begin
      acc_d = host_wr_data;
    end else if (ramp_tick) begin
      if (state_q == UP) begin
        acc_d = sum[8] ? 8'hFF : sum[7:0];
        if (acc_d == 8'hFF) state_d = loop_q ? DOWN : IDLE;
      end else begin
        acc_d = diff[8] ? 8'h00 : diff[7:0];
        if (acc_d == 8'h00) state_d = loop_q ? UP : IDLE;
      end
    end
  end

  always_comb begin
    ramp_req    = ramp_tick || (pend_q && !host_duty && !ctrl_dis);
    bank_en_d   = 1'b0;
    bank_addr_d = bank_addr_q;
    bank_data_d = bank_data_q;
    stall_d     = 1'b0;
    pend_d      = 1'b0;
    if (host_wr_valid) begin
      if (host_fwd) begin
        bank_en_d   = 1'b1;
        bank_addr_d = host_wr_addr;
        bank_data_d = host_wr_data;
      end
      stall_d = ramp_req;
      pend_d  = ramp_req;
    end else if (ramp_req) begin
      bank_en_d   = 1'b1;
      bank_addr_d = ADDR_DUTY;
      bank_data_d = acc_d;
    end
    loop_d   = host_ctrl ? host_wr_data[CTRL_LOOP_BIT] : loop_q;
    step_d   = host_ctrl ? host_wr_data[CTRL_STEP_MSB:CTRL_STEP_LSB] : step_q;
    period_d = host_period ? host_wr_data : period_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      loop_q      <= 1'b0;
      step_q      <= '0;
      period_q    <= '0;
      pend_q      <= 1'b0;
      bank_en_q   <= 1'b0;
      bank_addr_q <= '0;
      bank_data_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      loop_q      <= loop_d;
      step_q      <= step_d;
      period_q    <= period_d;
      pend_q      <= pend_d;
      bank_en_q   <= bank_en_d;
      bank_addr_q <= bank_addr_d;
      bank_data_q <= bank_data_d;
      stall_q     <= stall_d;
    end
  end

  assign bank_wr_en   = bank_en_q;
  assign bank_wr_addr = bank_addr_q;
  assign bank_wr_data = bank_data_q;
  assign ramp_busy    = (state_q != IDLE);
  assign ramp_stall   = stall_q;

`ifdef RAMP_DONE_IRQ_EN
  logic done_q, done_d;

  // Leaving an active state without a disable write means the endpoint was reached.
  always_comb begin
    done_d = (state_q != IDLE) && (state_d == IDLE) && !ctrl_dis;
  end

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_d;
  end

  assign ramp_done = done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_duty_ramp_arbiter.sv
// tb_duty_ramp_arbiter: directed vector table plus hand sequences for the ramp arbiter.
// Revision: 1.0
`default_nettype none

module tb_duty_ramp_arbiter;

  localparam int PRESCALE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_wr_valid;
  logic [6:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       bank_wr_en;
  logic [6:0] bank_wr_addr;
  logic [7:0] bank_wr_data;
  logic       ramp_busy;
  logic       ramp_stall;
`ifdef RAMP_DONE_IRQ_EN
  logic       ramp_done;
`endif

  duty_ramp_arbiter #(.PRESCALE(PRESCALE), .PRESCALE_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr_valid (host_wr_valid),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .bank_wr_en    (bank_wr_en),
    .bank_wr_addr  (bank_wr_addr),
    .bank_wr_data  (bank_wr_data),
    .ramp_busy     (ramp_busy),
    .ramp_stall    (ramp_stall)
`ifdef RAMP_DONE_IRQ_EN
    ,
    .ramp_done     (ramp_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [6:0] addr;
    logic [7:0] data;
    logic       e_en;
    logic [6:0] e_addr;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_stall;
    logic       e_done;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] a, input logic [7:0] d);
    host_wr_valid = v;
    host_wr_addr  = a;
    host_wr_data  = d;
  endtask

  task automatic add(input logic r, input logic v, input logic [6:0] a, input logic [7:0] d,
                     input logic ee, input logic [6:0] ea, input logic [7:0] ed,
                     input logic eb, input logic es, input logic edn);
    vecs[nvec] = '{r, v, a, d, ee, ea, ed, eb, es, edn};
    nvec++;
  endtask

  // Sequence runs with PRESCALE=2, RAMP_PERIOD=0: one tick every second cycle.
  initial begin
    //   rst vld addr   data   en  addr   data   busy stall done
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 1, 7'h02, 8'hA5, 1, 7'h02, 8'hA5, 0, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 1, 7'h06, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 1, 7'h05, 8'h11, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h01, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h02, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 1, 7'h01, 8'h3C, 1, 7'h01, 8'h3C, 1, 1, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h03, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h04, 1, 0, 0);
    add(0, 1, 7'h05, 8'hF3, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h13, 1, 0, 0);
    add(0, 1, 7'h04, 8'hF8, 1, 7'h04, 8'hF8, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'hFF, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'hF0, 1, 0, 0);
    add(0, 1, 7'h04, 8'h80, 1, 7'h04, 8'h80, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h71, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 1, 7'h05, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 1, 7'h05, 8'hF1, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'h80, 1, 0, 0);
    add(0, 1, 7'h04, 8'hF0, 1, 7'h04, 8'hF0, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 1, 7'h04, 8'hFF, 0, 0, 1);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 1, 7'h04, 8'h00, 1, 7'h04, 8'h00, 0, 0, 0);
    add(0, 1, 7'h05, 8'h11, 0, 7'h00, 8'h00, 1, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 1, 0, 0);
    add(1, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);
    add(0, 0, 7'h00, 8'h00, 0, 7'h00, 8'h00, 0, 0, 0);

    rst = 1'b1;
    drive(0, 7'h00, 8'h00);
    repeat (3) cyc();
    chk("reset bank_wr_en", 32'(bank_wr_en), 0);
    chk("reset bank_wr_addr", 32'(bank_wr_addr), 0);
    chk("reset bank_wr_data", 32'(bank_wr_data), 0);
    chk("reset ramp_busy", 32'(ramp_busy), 0);
    chk("reset ramp_stall", 32'(ramp_stall), 0);
`ifdef RAMP_DONE_IRQ_EN
    chk("reset ramp_done", 32'(ramp_done), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].vld, vecs[i].addr, vecs[i].data);
      cyc();
      chk($sformatf("vec%0d bank_wr_en", i), 32'(bank_wr_en), 32'(vecs[i].e_en));
      if (vecs[i].e_en || vecs[i].rst) begin
        chk($sformatf("vec%0d bank_wr_addr", i), 32'(bank_wr_addr), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d bank_wr_data", i), 32'(bank_wr_data), 32'(vecs[i].e_data));
      end
      chk($sformatf("vec%0d ramp_busy", i), 32'(ramp_busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d ramp_stall", i), 32'(ramp_stall), 32'(vecs[i].e_stall));
`ifdef RAMP_DONE_IRQ_EN
      chk($sformatf("vec%0d ramp_done", i), 32'(ramp_done), 32'(vecs[i].e_done));
`endif
    end
    rst = 1'b0;
    drive(0, 7'h00, 8'h00);

    // Full non-loop ramp 0 -> 255 with step 1, then the FSM returns to IDLE.
    drive(1, 7'h05, 8'h11);
    cyc();
    drive(0, 7'h00, 8'h00);
    for (int v = 1; v <= 255; v++) begin
      int w;
      w = 0;
      do begin
        cyc();
        w++;
      end while (!bank_wr_en && w < 6);
      if (!bank_wr_en) begin
        chk($sformatf("full ramp write %0d timeout", v), 0, 1);
        break;
      end
      if (v == 1 || v == 255)
        chk($sformatf("full ramp addr %0d", v), 32'(bank_wr_addr), 32'h04);
      chk($sformatf("full ramp data %0d", v), 32'(bank_wr_data), 32'(v));
      if (v == 255) begin
        chk("full ramp busy at end", 32'(ramp_busy), 0);
`ifdef RAMP_DONE_IRQ_EN
        chk("full ramp done pulse", 32'(ramp_done), 1);
`endif
      end
    end
    cyc();
    chk("after full ramp no write", 32'(bank_wr_en), 0);
`ifdef RAMP_DONE_IRQ_EN
    chk("after full ramp done low", 32'(ramp_done), 0);
`endif

    // RAMP_PERIOD=1 doubles the tick interval to 4 cycles; step 2.
    drive(1, 7'h04, 8'h00);
    cyc();
    drive(1, 7'h06, 8'h01);
    cyc();
    drive(1, 7'h05, 8'h21);
    cyc();
    drive(0, 7'h00, 8'h00);
    begin
      int w;
      w = 0;
      do begin
        cyc();
        w++;
      end while (!bank_wr_en && w < 10);
      chk("period first write latency", 32'(w), 4);
      chk("period first write data", 32'(bank_wr_data), 32'h02);
      w = 0;
      do begin
        cyc();
        w++;
      end while (!bank_wr_en && w < 10);
      chk("period interval", 32'(w), 4);
      chk("period second write data", 32'(bank_wr_data), 32'h04);
    end
    drive(1, 7'h05, 8'h00);
    cyc();
    drive(0, 7'h00, 8'h00);
    chk("period stop busy", 32'(ramp_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
